// File: rtl/png_chunk_gen_pkg.sv
// Shared constants, state encoding and output-word payload for the PNG chunk builder.
package png_pkg;

  localparam int unsigned DATA_WD  = 32;
  localparam int unsigned LEN_WD   = 31;
  localparam int unsigned WCNT_WD  = LEN_WD - 2;
  localparam int unsigned CRC_SLOT = 4;
  localparam int unsigned SLOT_WD  = $clog2(CRC_SLOT);

  // Standard PNG chunk type codes, first ASCII byte in the MSBs
  localparam logic [DATA_WD-1:0] IHDR = 32'h49484452;
  localparam logic [DATA_WD-1:0] IDAT = 32'h49444154;
  localparam logic [DATA_WD-1:0] IEND = 32'h49454E44;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TYPE     = 3'd1,
    DATA     = 3'd2,
    WAIT_CRC = 3'd3,
    EMIT     = 3'd4
  } state_t;

  // One word of the outgoing chunk stream
  typedef struct packed {
    logic               val;
    logic               lst;
    logic               done;
    logic [DATA_WD-1:0] dat;
  } chunk_word_t;

  // LENGTH field: byte count rounded down to whole words, MSB forced to 0
  function automatic logic [DATA_WD-1:0] length_word(input logic [WCNT_WD-1:0] wcnt);
    return {1'b0, wcnt, 2'b00};
  endfunction

endpackage

// File: rtl/png_chunk_gen.sv
// Wraps a word-aligned payload into a PNG chunk (LENGTH, TYPE, DATA..., CRC),
// feeding TYPE and DATA through the external word-serial crc32 engine.
module png_chunk_gen
  import png_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [DATA_WD-1:0] len_i,
  input  logic [DATA_WD-1:0] type_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  output logic               rdy_o,
  output logic               crc_start_o,
  output logic               crc_val_o,
  output logic [DATA_WD-1:0] crc_dat_o,
  output logic               crc_lst_o,
  input  logic               crc_done_i,
  input  logic [DATA_WD-1:0] crc_dat_i,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic               lst_o,
  output logic               done_o,
  output logic               busy_o
);

  state_t               state_q, state_d;
  logic [WCNT_WD-1:0]   rem_q, rem_d;
  logic [DATA_WD-1:0]   type_q, type_d;
  logic [SLOT_WD-1:0]   slot_q, slot_d;
  chunk_word_t          out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 unused_len;

  // Byte-granular length bits and the PNG-reserved MSB carry no information here
  assign unused_len = ^{len_i[DATA_WD-1], len_i[1:0]};

  // State, latched chunk fields and registered output word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      type_q  <= '0;
      slot_q  <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      slot_q  <= slot_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  // Next state, CRC handoff and next output word
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    type_d      = type_q;
    // Slot counter runs 1->2->3->0 after a handoff and parks at 0 (slot open)
    slot_d      = (slot_q == '0) ? '0 : slot_q + SLOT_WD'(1);
    out_d       = '0;
    busy_d      = busy_q;
    rdy_o       = 1'b0;
    crc_start_o = 1'b0;
    crc_val_o   = 1'b0;
    crc_dat_o   = '0;
    crc_lst_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          crc_start_o = 1'b1;
          rem_d       = len_i[LEN_WD-1:2];
          type_d      = type_i;
          out_d.val   = 1'b1;
          out_d.dat   = length_word(len_i[LEN_WD-1:2]);
          busy_d      = 1'b1;
          state_d     = TYPE;
        end
      end

      TYPE: begin
        crc_val_o = 1'b1;
        crc_dat_o = type_q;
        crc_lst_o = (rem_q == '0);
        slot_d    = SLOT_WD'(1);
        out_d.val = 1'b1;
        out_d.dat = type_q;
        state_d   = (rem_q == '0) ? WAIT_CRC : DATA;
      end

      DATA: begin
        rdy_o = (slot_q == '0);
        if (val_i && (slot_q == '0)) begin
          crc_val_o = 1'b1;
          crc_dat_o = dat_i;
          crc_lst_o = (rem_q == WCNT_WD'(1));
          rem_d     = rem_q - WCNT_WD'(1);
          slot_d    = SLOT_WD'(1);
          out_d.val = 1'b1;
          out_d.dat = dat_i;
          if (rem_q == WCNT_WD'(1)) begin
            state_d = WAIT_CRC;
          end
        end
      end

      WAIT_CRC: begin
        if (crc_done_i) begin
          out_d.val  = 1'b1;
          out_d.lst  = 1'b1;
          out_d.done = 1'b1;
          out_d.dat  = crc_dat_i;
          busy_d     = 1'b0;
          state_d    = EMIT;
        end
      end

      EMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign val_o  = out_q.val;
  assign dat_o  = out_q.dat;
  assign lst_o  = out_q.lst;
  assign done_o = out_q.done;
  assign busy_o = busy_q;

endmodule
